seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl_pkg.sv | 23 ++
 rtl/seg_scan_ctrl_decode.sv | 13 +
 rtl/seg_scan_ctrl.sv | 91 +++++++++
 tb/tb_seg_scan_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan controller.
// The seg_scan_ctrl top honours the SEG_SCAN_BLANK_EN macro (ghost-suppression blanking).
package seg_scan_ctrl_pkg;

  localparam int unsigned NUM_DIGITS   = 4;
  localparam int unsigned BLANK_CYCLES = 4;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low segment codes {g,f,e,d,c,b,a}, indexed by hex nibble.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b0100111, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  points;
  } frame_t;

endpackage

// File: rtl/seg_scan_ctrl_decode.sv
// Combinational hex nibble to active-low 7-segment decoder.
module seg_decode
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_TABLE[nibble];
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with frame-atomic data update.
// Define SEG_SCAN_BLANK_EN to blank the first BLANK_CYCLES cycles of every digit slot.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 50000,
  parameter int unsigned NUM_DIGITS = seg_scan_ctrl_pkg::NUM_DIGITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  en_mask,
  input  logic        load,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt, cnt_next;
  logic [1:0]       idx, idx_next;
  frame_t           active, active_next, pending;
  logic             pending_valid;
  logic             tick, wrap, show;
  logic [3:0]       nibble;
  logic [6:0]       dec_seg;

  // Outputs are registered from next-state values so they line up with idx/cnt.
  always_comb begin
    tick        = (cnt == CNT_W'(CLK_DIV - 1));
    wrap        = tick && (idx == 2'(NUM_DIGITS - 1));
    cnt_next    = tick ? '0 : cnt + 1'b1;
    idx_next    = wrap ? '0 : (tick ? idx + 2'd1 : idx);
    active_next = active;
    if (wrap && load) begin
      active_next = '{digits: data, points: dp_in};
    end else if (wrap && pending_valid) begin
      active_next = pending;
    end
    nibble = active_next.digits[{idx_next, 2'b00} +: 4];
    show   = en_mask[idx_next];
`ifdef SEG_SCAN_BLANK_EN
    if (cnt_next < CNT_W'(BLANK_CYCLES)) begin
      show = 1'b0;
    end
`endif
  end

  seg_decode u_decode (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      idx           <= '0;
      active        <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      an            <= '1;
      seg           <= SEG_BLANK;
      dp            <= 1'b1;
      frame_done    <= 1'b0;
    end else begin
      cnt        <= cnt_next;
      idx        <= idx_next;
      active     <= active_next;
      frame_done <= wrap;
      if (load && !wrap) begin
        pending       <= '{digits: data, points: dp_in};
        pending_valid <= 1'b1;
      end else if (wrap) begin
        pending_valid <= 1'b0;
      end
      if (show) begin
        an  <= ~(4'b0001 << idx_next);
        seg <= dec_seg;
        dp  <= ~active_next.points[idx_next];
      end else begin
        an  <= '1;
        seg <= SEG_BLANK;
        dp  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (CLK_DIV = 8): frame-level model plus literal pins.
module tb_seg_scan_ctrl;

  localparam int DIV   = 8;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  en_mask = 4'hF;
  logic        load = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  seg_scan_ctrl #(.CLK_DIV(DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .data       (data),
    .dp_in      (dp_in),
    .en_mask    (en_mask),
    .load       (load),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'b1000000;  4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;  4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;  4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;  4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b0100111;  4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;  default: hex7 = 7'b0001110;
    endcase
  endfunction

  // Model: k counts edges since the last reset edge; slot/digit follow from k.
  int          k = 0;
  bit          in_rst = 1'b1;
  bit          chk_en = 1'b0;
  logic [15:0] m_data = '0, m_pdata = '0;
  logic [3:0]  m_dp = '0, m_pdp = '0, m_en = 4'hF;
  bit          m_pv = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      k = 0; in_rst = 1'b1; m_data = '0; m_dp = '0; m_pv = 1'b0;
    end else begin
      k++;
      in_rst = 1'b0;
      if (k % FRAME == 0) begin
        if (load) begin m_data = data; m_dp = dp_in; end
        else if (m_pv) begin m_data = m_pdata; m_dp = m_pdp; end
        m_pv = 1'b0;
      end else if (load) begin
        m_pdata = data; m_pdp = dp_in; m_pv = 1'b1;
      end
      m_en = en_mask;
    end
  end

  always @(negedge clk) begin
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_fd, show;
    logic [3:0] one;
    int         slot, pos;
    if (chk_en) begin
      one = 4'b0001;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
      if (!in_rst) begin
        pos  = k % DIV;
        slot = (k / DIV) % 4;
        show = m_en[slot];
`ifdef SEG_SCAN_BLANK_EN
        if (pos < 4) show = 1'b0;
`endif
        if (show) begin
          e_an  = ~(one << slot);
          e_seg = hex7(4'((m_data >> (4 * slot)) & 16'hF));
          e_dp  = ~m_dp[slot];
        end
        e_fd = (k > 0) && (k % FRAME == 0);
      end
      checks++;
      if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
        errors++;
        $display("FAIL model k=%0d: an=%b seg=%b dp=%b fd=%b, expected an=%b seg=%b dp=%b fd=%b",
                 k, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
      end
    end
  end

  task automatic wait_k(input int target);
    int n;
    for (n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (!in_rst && k == target) return;
    end
    checks++; errors++;
    $display("FAIL timeout waiting for k=%0d (now k=%0d)", target, k);
  endtask

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp_v);
    end
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_outputs", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
    chk("reset_fd", {11'd0, frame_done}, 12'd0);

    // Load 1234 early in frame 0; frame 0 keeps showing zeros
    rst = 1'b0; load = 1'b1; data = 16'h1234; dp_in = 4'b0010;
    wait_k(1);
    load = 1'b0;
`ifdef SEG_SCAN_BLANK_EN
    wait_k(2); chk("blank_head", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
`else
    wait_k(2); chk("noblank_head", {an, seg, dp}, {4'b1110, 7'b1000000, 1'b1});
`endif
    wait_k(5);  chk("frame0_untorn", {an, seg, dp}, {4'b1110, 7'b1000000, 1'b1});
    wait_k(32); chk("frame_done_32", {11'd0, frame_done}, 12'd1);
    wait_k(33); chk("frame_done_33", {11'd0, frame_done}, 12'd0);
    wait_k(37); chk("d0_is_4", {an, seg, dp}, {4'b1110, 7'b0011001, 1'b1});
    wait_k(45); chk("d1_is_3", {an, seg, dp}, {4'b1101, 7'b0110000, 1'b0});
    wait_k(53); chk("d2_is_2", {an, seg, dp}, {4'b1011, 7'b0100100, 1'b1});
    wait_k(61); chk("d3_is_1", {an, seg, dp}, {4'b0111, 7'b1111001, 1'b1});

    // Two loads in one frame: only the last one shows, from the next frame
    dp_in = 4'b0000;
    wait_k(70); load = 1'b1; data = 16'hAAAA;
    wait_k(71); load = 1'b0;
    wait_k(80); load = 1'b1; data = 16'h5555;
    wait_k(81); load = 1'b0;
    wait_k(85);  chk("still_1234", {an, seg, dp}, {4'b1011, 7'b0100100, 1'b1});
    wait_k(101); chk("now_5555", {an, seg, dp}, {4'b1110, 7'b0010010, 1'b1});

    // Load coincident with the wrap tick goes straight to active
    wait_k(127); load = 1'b1; data = 16'hFFFF;
    wait_k(128); load = 1'b0;
    wait_k(133); chk("wrap_load_F", {an, seg, dp}, {4'b1110, 7'b0001110, 1'b1});

    // Masked digits blank, scanning continues
    en_mask = 4'b0101;
    wait_k(165); chk("mask_d0_on", {an, seg, dp}, {4'b1110, 7'b0001110, 1'b1});
    wait_k(173); chk("mask_d1_off", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
    wait_k(189); chk("mask_d3_off", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
    wait_k(192); chk("mask_frame_done", {11'd0, frame_done}, 12'd1);

    // Reset mid-frame with a load pending: pending is discarded
    en_mask = 4'hF;
    wait_k(200); load = 1'b1; data = 16'h9876;
    wait_k(201); load = 1'b0;
    wait_k(210); rst = 1'b1;
    @(negedge clk);
    chk("midreset_blank", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
    rst = 1'b0;
    wait_k(5);  chk("post_rst_d0", {an, seg, dp}, {4'b1110, 7'b1000000, 1'b1});
    wait_k(7);  chk("post_rst_d0_end", {an, seg, dp}, {4'b1110, 7'b1000000, 1'b1});
    wait_k(13); chk("post_rst_tick8", {an, seg, dp}, {4'b1101, 7'b1000000, 1'b1});
    wait_k(37); chk("pending_dropped", {an, seg, dp}, {4'b1110, 7'b1000000, 1'b1});
    wait_k(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
